// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the two-master SRAM-like bus arbiter.
package sram_bus_arbiter_pkg;

  localparam int unsigned STATE_W = 2;

  // Transaction phase of the shared slave port.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Owner / winner encoding.
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/sram_bus_arbiter_pick.sv
// Combinational winner select between the inst and data channels.
// Ports:
//   inst_req, data_req : active requests
//   last_owner         : channel granted at the previous address accept
//   rr_en              : 1 = round-robin on ties, 0 = data over inst
//   winner             : OWN_INST / OWN_DATA
module arb_pick
  import sram_bus_arbiter_pkg::*;
(
  input  logic inst_req,
  input  logic data_req,
  input  logic last_owner,
  input  logic rr_en,
  output logic winner
);

  always_comb begin
    winner = OWN_INST;
    if (rr_en && inst_req && data_req) begin
      // Tie: favour whoever was not granted last time.
      winner = ~last_owner;
    end else if (data_req) begin
      winner = OWN_DATA;
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like slave port between the IF (inst) and MEM (data)
// channels, one outstanding transaction at a time.
// Build option: define SRAM_ARB_RR_EN for round-robin tie breaking;
// otherwise data has fixed priority over inst.
// Ports:
//   clk, rst                         : clock, async active-high reset
//   inst_req/addr, inst_*_ok, rdata  : IF channel
//   data_req/wr/wstrb/addr/wdata,
//   data_*_ok, data_rdata            : MEM channel
//   mem_req/wr/wstrb/addr/wdata,
//   mem_addr_ok/data_ok/rdata        : slave port
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;

  state_t state, state_nxt;
  logic   owner, owner_nxt;
  logic   winner;
  logic   sel;
  logic   last_owner;
  logic   rr_en;

`ifdef SRAM_ARB_RR_EN
  // Remembers the channel granted at the most recent address accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= OWN_DATA;
    end else if (mem_req && mem_addr_ok) begin
      last_owner <= sel;
    end
  end
  assign rr_en = 1'b1;
`else
  assign last_owner = OWN_DATA;
  assign rr_en      = 1'b0;
`endif

  arb_pick u_pick (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .last_owner (last_owner),
    .rr_en      (rr_en),
    .winner     (winner)
  );

  // In IDLE the live winner drives the slave; afterwards the grant is locked.
  assign sel = (state == ST_IDLE) ? winner : owner;

  // Slave request fields; the inst channel never writes.
  assign mem_addr   = (sel == OWN_DATA) ? data_addr  : inst_addr;
  assign mem_wr     = (sel == OWN_DATA) ? data_wr    : 1'b0;
  assign mem_wstrb  = (sel == OWN_DATA) ? data_wstrb : STRB_W'(0);
  assign mem_wdata  = (sel == OWN_DATA) ? data_wdata : DATA_W'(0);

  // Read data is shared; only the owner's data_ok qualifies it.
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  // State and owner registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= OWN_INST;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // Next-state, request and handshake routing.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    mem_req      = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state)
      ST_IDLE: begin
        mem_req = inst_req | data_req;
        if (mem_req) begin
          owner_nxt    = winner;
          inst_addr_ok = mem_addr_ok && (winner == OWN_INST);
          data_addr_ok = mem_addr_ok && (winner == OWN_DATA);
          state_nxt    = mem_addr_ok ? ST_DATA : ST_ADDR;
        end
      end
      ST_ADDR: begin
        mem_req      = 1'b1;
        inst_addr_ok = mem_addr_ok && (owner == OWN_INST);
        data_addr_ok = mem_addr_ok && (owner == OWN_DATA);
        if (mem_addr_ok) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (mem_data_ok) begin
          inst_data_ok = (owner == OWN_INST);
          data_data_ok = (owner == OWN_DATA);
          state_nxt    = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed self-checking bench for sram_bus_arbiter.
module tb_sram_bus_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok, inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic              data_req, data_wr;
  logic [STRB_W-1:0] data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok, data_data_ok;
  logic [DATA_W-1:0] data_rdata;
  logic              mem_req, mem_wr;
  logic [STRB_W-1:0] mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok, mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic tb_last;  // expected round-robin history: 1 = data granted last

  always #5 clk = ~clk;

  sram_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, then let inputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One tied-request round: both channels request together, first winner is
  // served, then the loser is served from the following IDLE cycle.
  task automatic tie_round(input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da);
    logic first_data;
`ifdef SRAM_ARB_RR_EN
    first_data = ~tb_last;
`else
    first_data = 1'b1;
`endif
    inst_req = 1'b1; inst_addr = ia;
    data_req = 1'b1; data_wr = 1'b0; data_addr = da; data_wstrb = 4'hF;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b0;
    #1;
    chk("tie1_mem_addr", 64'(mem_addr), first_data ? 64'(da) : 64'(ia));
    chk("tie1_inst_aok", 64'(inst_addr_ok), 64'(!first_data));
    chk("tie1_data_aok", 64'(data_addr_ok), 64'(first_data));
    tb_last = first_data;
    tick();
    if (first_data) data_req = 1'b0; else inst_req = 1'b0;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b0;
    #1;
    chk("tie_wait_req", 64'(mem_req), 64'(0));
    chk("tie_wait_inst_aok", 64'(inst_addr_ok), 64'(0));
    chk("tie_wait_data_aok", 64'(data_addr_ok), 64'(0));
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'hCAFE0001;
    #1;
    chk("tie1_data_dok", 64'(data_data_ok), 64'(first_data));
    chk("tie1_inst_dok", 64'(inst_data_ok), 64'(!first_data));
    chk("tie1_inst_aok_rsp", 64'(inst_addr_ok), 64'(0));
    tick();
    mem_data_ok = 1'b0;
    #1;
    chk("tie2_mem_addr", 64'(mem_addr), first_data ? 64'(ia) : 64'(da));
    chk("tie2_inst_aok", 64'(inst_addr_ok), 64'(first_data));
    chk("tie2_data_aok", 64'(data_addr_ok), 64'(!first_data));
    tb_last = !first_data;
    tick();
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'hCAFE0002;
    #1;
    chk("tie2_inst_dok", 64'(inst_data_ok), 64'(first_data));
    chk("tie2_data_dok", 64'(data_data_ok), 64'(!first_data));
    chk("tie2_rdata", 64'(first_data ? inst_rdata : data_rdata), 64'h0000_0000_CAFE_0002);
    tick();
    mem_data_ok = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tb_last = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_inst_aok", 64'(inst_addr_ok), 64'(0));
    chk("rst_data_aok", 64'(data_addr_ok), 64'(0));
    chk("rst_inst_dok", 64'(inst_data_ok), 64'(0));
    chk("rst_data_dok", 64'(data_data_ok), 64'(0));
    rst = 1'b0;
    tick();

    // Inst-only read with a zero-wait slave.
    inst_req = 1'b1; inst_addr = 32'h1C000000; mem_addr_ok = 1'b1;
    #1;
    chk("if_mem_req", 64'(mem_req), 64'(1));
    chk("if_mem_addr", 64'(mem_addr), 64'h1C000000);
    chk("if_mem_wr", 64'(mem_wr), 64'(0));
    chk("if_inst_aok", 64'(inst_addr_ok), 64'(1));
    chk("if_data_aok", 64'(data_addr_ok), 64'(0));
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h02800C0C;
    #1;
    chk("if_data_req", 64'(mem_req), 64'(0));
    chk("if_inst_dok", 64'(inst_data_ok), 64'(1));
    chk("if_inst_rdata", 64'(inst_rdata), 64'h02800C0C);
    chk("if_data_dok", 64'(data_data_ok), 64'(0));
    tick();
    // Back in IDLE; a spurious response must be ignored.
    #1;
    chk("spur_inst_dok", 64'(inst_data_ok), 64'(0));
    chk("spur_data_dok", 64'(data_data_ok), 64'(0));
    mem_data_ok = 1'b0;
    tick();

    // Async reset between accept and response.
    inst_req = 1'b1; inst_addr = 32'h1C000020; mem_addr_ok = 1'b1;
    #1;
    chk("rstmid_aok", 64'(inst_addr_ok), 64'(1));
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    #1;
    rst = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h11112222;
    #1;
    chk("rstmid_inst_dok", 64'(inst_data_ok), 64'(0));
    rst = 1'b0;
    tick();
    chk("rstmid_late_dok", 64'(inst_data_ok), 64'(0));
    mem_data_ok = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1C000024; mem_addr_ok = 1'b1;
    #1;
    chk("rstmid_next_aok", 64'(inst_addr_ok), 64'(1));
    chk("rstmid_next_addr", 64'(mem_addr), 64'h1C000024);
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h33334444;
    #1;
    chk("rstmid_next_dok", 64'(inst_data_ok), 64'(1));
    tick();
    mem_data_ok = 1'b0;

    // Fresh reset so the first tie starts from reset history.
    rst = 1'b1; #2; rst = 1'b0; tb_last = 1'b1;
    tick();
    tie_round(32'h1C000004, 32'h00000100);
    tie_round(32'h1C000008, 32'h00000104);

    // Grant lock with a write arriving while inst waits for accept.
    inst_req = 1'b1; inst_addr = 32'h1C000010; mem_addr_ok = 1'b0;
    #1;
    chk("lock0_req", 64'(mem_req), 64'(1));
    chk("lock0_aok", 64'(inst_addr_ok), 64'(0));
    tick();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
    data_addr = 32'h2000; data_wdata = 32'hDEADBEEF;
    for (int c = 1; c <= 2; c++) begin
      #1;
      chk("lock_mem_addr", 64'(mem_addr), 64'h1C000010);
      chk("lock_mem_wr", 64'(mem_wr), 64'(0));
      chk("lock_data_aok", 64'(data_addr_ok), 64'(0));
      tick();
    end
    mem_addr_ok = 1'b1;
    #1;
    chk("lock3_mem_addr", 64'(mem_addr), 64'h1C000010);
    chk("lock3_inst_aok", 64'(inst_addr_ok), 64'(1));
    chk("lock3_data_aok", 64'(data_addr_ok), 64'(0));
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h55556666;
    #1;
    chk("lock_inst_dok", 64'(inst_data_ok), 64'(1));
    tick();
    mem_data_ok = 1'b0; mem_addr_ok = 1'b1;
    #1;
    chk("wr_data_aok", 64'(data_addr_ok), 64'(1));
    chk("wr_mem_addr", 64'(mem_addr), 64'h2000);
    chk("wr_mem_wr", 64'(mem_wr), 64'(1));
    chk("wr_mem_wstrb", 64'(mem_wstrb), 64'(4'b0011));
    chk("wr_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    tick();
    data_req = 1'b0; mem_addr_ok = 1'b0;
    #1;
    chk("wr_wait_dok", 64'(data_data_ok), 64'(0));
    tick();
    mem_data_ok = 1'b1;
    #1;
    chk("wr_data_dok", 64'(data_data_ok), 64'(1));
    chk("wr_inst_dok", 64'(inst_data_ok), 64'(0));
    tick();
    mem_data_ok = 1'b0;
    #1;
    chk("end_idle_req", 64'(mem_req), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
